// File: rtl/hotplate_pkg.sv
// Shared types and helpers for the hotplate power scheduler slice.
// Holds the scheduler state encoding, level width and request clamping.
package hotplate_pkg;

    typedef enum logic [1:0] {
        LATCH  = 2'd0,
        REDUCE = 2'd1,
        RUN    = 2'd2
    } state_t;

    localparam int LEVEL_W           = 4;
    localparam int MAX_LEVEL_DEFAULT = 9;

    // A switched-off plate asks for nothing; over-range requests saturate.
    function automatic logic [LEVEL_W-1:0] clamp_level(
        input logic               en,
        input logic [LEVEL_W-1:0] lvl,
        input logic [LEVEL_W-1:0] max_lvl
    );
        logic [LEVEL_W-1:0] res;
        if (!en) begin
            res = 4'd0;
        end else if (lvl > max_lvl) begin
            res = max_lvl;
        end else begin
            res = lvl;
        end
        return res;
    endfunction

endpackage

// File: rtl/hotplate_slot_timer.sv
// Slot prescaler: divides clk into slots and counts MAX_LEVEL slots per window.
// Held at zero whenever run is low so every window starts at slot 0, tick 0.
module hotplate_slot_timer
    import hotplate_pkg::*;
#(
    parameter int MAX_LEVEL = MAX_LEVEL_DEFAULT,
    parameter int TICK_DIV  = 5_000_000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           run,
    output logic [$clog2(MAX_LEVEL+1)-1:0] slot,
    output logic                           slot_wrap
);

    localparam int SLOT_W = $clog2(MAX_LEVEL + 1);
    localparam int TICK_W = $clog2(TICK_DIV);

    logic [TICK_W-1:0] tick_r;
    logic [SLOT_W-1:0] slot_r;
    logic              tick_last_s;

    assign tick_last_s = (tick_r == TICK_W'(TICK_DIV - 1));
    assign slot_wrap   = run && tick_last_s && (slot_r == SLOT_W'(MAX_LEVEL - 1));
    assign slot        = slot_r;

    // Tick prescaler and slot counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_r <= '0;
            slot_r <= '0;
        end else if (!run) begin
            tick_r <= '0;
            slot_r <= '0;
        end else if (tick_last_s) begin
            tick_r <= '0;
            slot_r <= slot_wrap ? SLOT_W'(0) : slot_r + SLOT_W'(1);
        end else begin
            tick_r <= tick_r + TICK_W'(1);
        end
    end

endmodule

// File: rtl/hotplate_power_scheduler.sv
// Shares a power budget among hotplates: latch, round-robin trim, slot-duty relays.
// Define HOTPLATE_STAGGER_EN to rotate each plate's on-slots by its index.
module hotplate_power_scheduler
    import hotplate_pkg::*;
#(
    parameter int N_PLATES  = 2,
    parameter int MAX_LEVEL = MAX_LEVEL_DEFAULT,
    parameter int BUDGET    = 12,
    parameter int TICK_DIV  = 5_000_000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_PLATES-1:0]           plate_en,
    input  logic [LEVEL_W*N_PLATES-1:0]   req_level,
    output logic [N_PLATES-1:0]           heater_on,
    output logic [LEVEL_W*N_PLATES-1:0]   grant_level,
    output logic                          window_start,
    output logic                          throttled
);

    localparam int SUM_W  = $clog2(N_PLATES * MAX_LEVEL + 1);
    localparam int PTR_W  = (N_PLATES > 1) ? $clog2(N_PLATES) : 1;
    localparam int SLOT_W = $clog2(MAX_LEVEL + 1);

    state_t             state_r;
    logic [PTR_W-1:0]   rr_ptr_r;
    logic [PTR_W-1:0]   rr_next_s;
    logic [SUM_W-1:0]   sum_r;
    logic [SUM_W-1:0]   lsum_s;
    logic [LEVEL_W-1:0] grant_r [N_PLATES];
    logic [LEVEL_W-1:0] ref_r   [N_PLATES];
    logic [LEVEL_W-1:0] clamp_s [N_PLATES];
    logic [N_PLATES-1:0] heat_s;
    logic               thr_s;
    logic               over_s;
    logic [SLOT_W-1:0]  slot_s;
    logic               slot_wrap_s;
    logic               run_s;

    assign run_s = (state_r == RUN);

    hotplate_slot_timer #(
        .MAX_LEVEL (MAX_LEVEL),
        .TICK_DIV  (TICK_DIV)
    ) u_slot_timer (
        .clk       (clk),
        .rst       (rst),
        .run       (run_s),
        .slot      (slot_s),
        .slot_wrap (slot_wrap_s)
    );

    // Clamped requests and their sum, sampled only in LATCH.
    always_comb begin
        lsum_s = '0;
        for (int i = 0; i < N_PLATES; i++) begin
            clamp_s[i] = clamp_level(plate_en[i], req_level[LEVEL_W*i +: LEVEL_W],
                                     LEVEL_W'(MAX_LEVEL));
            lsum_s     = lsum_s + SUM_W'(clamp_s[i]);
        end
    end

    // Round-robin pointer successor, budget test and throttle detection.
    always_comb begin
        if (rr_ptr_r == PTR_W'(N_PLATES - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = rr_ptr_r + PTR_W'(1);
        end
        over_s = (int'(sum_r) > BUDGET);
        thr_s  = 1'b0;
        for (int i = 0; i < N_PLATES; i++) begin
            thr_s = thr_s | (grant_r[i] < ref_r[i]);
        end
    end

    // Per-plate relay demand for the current slot.
    always_comb begin
        for (int i = 0; i < N_PLATES; i++) begin
`ifdef HOTPLATE_STAGGER_EN
            heat_s[i] = (((int'(slot_s) + MAX_LEVEL - (i % MAX_LEVEL)) % MAX_LEVEL)
                         < int'(grant_r[i]));
`else
            heat_s[i] = (int'(slot_s) < int'(grant_r[i]));
`endif
            grant_level[LEVEL_W*i +: LEVEL_W] = grant_r[i];
        end
    end

    // Window sequencer: latch requests, trim to budget, then run the slots.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= LATCH;
            rr_ptr_r     <= '0;
            sum_r        <= '0;
            heater_on    <= '0;
            window_start <= 1'b0;
            throttled    <= 1'b0;
            for (int i = 0; i < N_PLATES; i++) begin
                grant_r[i] <= '0;
                ref_r[i]   <= '0;
            end
        end else begin
            case (state_r)
                LATCH: begin
                    for (int i = 0; i < N_PLATES; i++) begin
                        grant_r[i] <= clamp_s[i];
                        ref_r[i]   <= clamp_s[i];
                    end
                    sum_r        <= lsum_s;
                    heater_on    <= '0;
                    window_start <= 1'b0;
                    state_r      <= REDUCE;
                end
                REDUCE: begin
                    heater_on <= '0;
                    rr_ptr_r  <= rr_next_s;
                    if (!over_s) begin
                        window_start <= 1'b1;
                        throttled    <= thr_s;
                        state_r      <= RUN;
                    end else begin
                        window_start <= 1'b0;
                        // A plate already at zero just passes its turn on.
                        if (grant_r[rr_ptr_r] != '0) begin
                            grant_r[rr_ptr_r] <= grant_r[rr_ptr_r] - LEVEL_W'(1);
                            sum_r             <= sum_r - SUM_W'(1);
                        end
                    end
                end
                RUN: begin
                    window_start <= 1'b0;
                    if (slot_wrap_s) begin
                        heater_on <= '0;
                        state_r   <= LATCH;
                    end else begin
                        heater_on <= heat_s;
                    end
                end
                default: begin
                    heater_on    <= '0;
                    window_start <= 1'b0;
                    state_r      <= LATCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hotplate_power_scheduler.sv
// Randomized self-checking bench for hotplate_power_scheduler (N=2, BUDGET=12, TICK_DIV=4).
// Reference model trims grants from the request rules and predicts relay state per cycle.
module tb_hotplate_power_scheduler;

    localparam int N      = 2;
    localparam int MAXL   = 9;
    localparam int BUDGET = 12;
    localparam int TDIV   = 4;
    localparam int RUNLEN = MAXL * TDIV;
`ifdef HOTPLATE_STAGGER_EN
    localparam bit STAG = 1'b1;
`else
    localparam bit STAG = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] plate_en = 2'b00;
    logic [7:0] req_level = 8'h00;
    logic [1:0] heater_on;
    logic [7:0] grant_level;
    logic       window_start;
    logic       throttled;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [3:0] pend_r [N];
    logic [1:0] pend_en;
    int         mdl_ptr = 0;
    int         exp_g [N];
    int         exp_thr;
    int         exp_steps;

    hotplate_power_scheduler #(
        .N_PLATES  (N),
        .MAX_LEVEL (MAXL),
        .BUDGET    (BUDGET),
        .TICK_DIV  (TDIV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .plate_en     (plate_en),
        .req_level    (req_level),
        .heater_on    (heater_on),
        .grant_level  (grant_level),
        .window_start (window_start),
        .throttled    (throttled)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic finish_tb();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    endtask

    task automatic set_inputs(input logic [3:0] r0, input logic [3:0] r1, input logic [1:0] en);
        req_level = {r1, r0};
        plate_en  = en;
        pend_r[0] = r0;
        pend_r[1] = r1;
        pend_en   = en;
    endtask

    // Grants for the pending requests, trimmed one unit per turn from the shared pointer.
    task automatic model_window();
        int sum;
        int req [N];
        sum = 0;
        for (int i = 0; i < N; i++) begin
            req[i]   = pend_en[i] ? ((int'(pend_r[i]) > MAXL) ? MAXL : int'(pend_r[i])) : 0;
            exp_g[i] = req[i];
            sum     += req[i];
        end
        exp_steps = 0;
        while (sum > BUDGET) begin
            if (exp_g[mdl_ptr] > 0) begin
                exp_g[mdl_ptr]--;
                sum--;
            end
            mdl_ptr = (mdl_ptr + 1) % N;
            exp_steps++;
        end
        mdl_ptr = (mdl_ptr + 1) % N;
        exp_thr = ((exp_g[0] < req[0]) || (exp_g[1] < req[1])) ? 1 : 0;
    endtask

    // Relay state k cycles after window_start: reflects the slot of the previous cycle.
    function automatic logic [1:0] exp_heat(input int k);
        logic [1:0] h;
        int s;
        int pos;
        h = 2'b00;
        if (k > 0) begin
            s = (k - 1) / TDIV;
            for (int i = 0; i < N; i++) begin
                pos  = STAG ? ((s + MAXL - (i % MAXL)) % MAXL) : s;
                h[i] = (pos < exp_g[i]);
            end
        end
        return h;
    endfunction

    task automatic window(input int lat_base, input logic [3:0] r0, input logic [3:0] r1,
                          input logic [1:0] nen, input int reset_at);
        int n;
        int chg;
        logic [3:0] g0;
        logic [3:0] g1;
        model_window();
        g0 = exp_g[0][3:0];
        g1 = exp_g[1][3:0];
        n  = 0;
        do begin
            @(negedge clk);
            n++;
            if (!window_start) check_eq("heater_idle", {30'd0, heater_on}, 32'd0);
        end while (!window_start && n < 200);
        if (!window_start) begin
            check_eq("ws_timeout", 32'd0, 32'd1);
            finish_tb();
        end
        check_eq("latency", n, lat_base + exp_steps);
        check_eq("grant", {24'd0, grant_level}, {24'd0, g1, g0});
        check_eq("throttled", {31'd0, throttled}, exp_thr);
        chg = $urandom_range(1, RUNLEN - 2);
        for (int k = 0; k < RUNLEN; k++) begin
            if (k > 0) begin
                @(negedge clk);
                check_eq("ws_pulse", {31'd0, window_start}, 32'd0);
            end
            check_eq("heater", {30'd0, heater_on}, {30'd0, exp_heat(k)});
            if (k == RUNLEN - 1) check_eq("throttled_hold", {31'd0, throttled}, exp_thr);
            if (k == chg) set_inputs(r0, r1, nen);
            if (k == reset_at) begin
                set_inputs(r0, r1, nen);
                rst = 1'b0;
                #1;
                check_eq("rst_heater", {30'd0, heater_on}, 32'd0);
                check_eq("rst_grant", {24'd0, grant_level}, 32'd0);
                check_eq("rst_throttled", {31'd0, throttled}, 32'd0);
                check_eq("rst_ws", {31'd0, window_start}, 32'd0);
                @(negedge clk);
                @(negedge clk);
                rst     = 1'b1;
                mdl_ptr = 0;
                return;
            end
        end
    endtask

    initial begin
        set_inputs(4'd5, 4'd6, 2'b11);
        repeat (3) @(negedge clk);
        check_eq("reset_heater", {30'd0, heater_on}, 32'd0);
        check_eq("reset_grant", {24'd0, grant_level}, 32'd0);
        check_eq("reset_ws", {31'd0, window_start}, 32'd0);
        check_eq("reset_throttled", {31'd0, throttled}, 32'd0);
        rst = 1'b1;
        window(2, 4'd9,  4'd9, 2'b11, -1);
        window(3, 4'd9,  4'd9, 2'b11, -1);
        window(3, 4'd12, 4'd3, 2'b01, -1);
        window(3, 4'd2,  4'd2, 2'b11, -1);
        window(3, 4'd8,  4'd8, 2'b11, -1);
        for (int w = 0; w < 6; w++) begin
            window(3, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   2'($urandom_range(0, 3)), -1);
        end
        window(3, 4'd5, 4'd6, 2'b11, -1);
        window(3, 4'd3, 4'd3, 2'b11, 6);
        window(2, 4'd7, 4'd4, 2'b11, -1);
        window(3, 4'd0, 4'd15, 2'b10, -1);
        window(3, 4'd0, 4'd0, 2'b00, -1);
        finish_tb();
    end

endmodule
